// File: rtl/cnn_conv3x3_acc.sv
// Binary 3x3 convolution stage: serial 9-tap accumulate, bias, ReLU, shift, saturate,
// with a single-entry valid/ready output slot and per-frame window counting.
module cnn_conv3x3_acc #(
  parameter int              WIN_PER_FRAME = 676,
  parameter logic signed [7:0] BIAS        = 8'sd0,
  parameter int              OUT_SHIFT     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_vld,
  input  logic       pix,
  output logic       bsy,
  input  logic       w_wr,
  input  logic [3:0] w_addr,
  input  logic [7:0] w_data,
  input  logic       frame_clr,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [7:0] out_data,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic signed [7:0]  w_q [9];
  logic signed [7:0]  w_d [9];
  logic signed [11:0] acc_q, acc_d;
  logic [3:0]         tap_q, tap_d;
  logic [9:0]         win_cnt_q, win_cnt_d;
  logic               out_vld_q, out_vld_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               last_q, last_d;
  logic               frame_done_q, frame_done_d;

  logic signed [7:0]  tap_w_s;
  logic signed [11:0] tap_ext_s;
  logic signed [11:0] sum_s;
  logic signed [11:0] shr_s;
  logic [7:0]         val_s;
  logic [9:0]         cnt_inc_s;
  logic               last_win_s;
  logic               accept_s;
  logic               slot_free_s;
  logic               we_s;

  // Weight selected by the current tap, sign-extended for accumulation.
  always_comb begin
    tap_w_s = 8'sd0;
    for (int i = 0; i < 9; i++) begin
      if (tap_q == 4'(i)) begin
        tap_w_s = w_q[i];
      end else begin
        tap_w_s = tap_w_s;
      end
    end
    tap_ext_s = {{4{tap_w_s[7]}}, tap_w_s};
  end

  // Post-processing of the finished sum: bias, ReLU, shift, saturate to 8 bits.
  always_comb begin
    sum_s = acc_q + {{4{BIAS[7]}}, BIAS};
    shr_s = sum_s >>> OUT_SHIFT;
    if (sum_s[11]) begin
      val_s = 8'd0;
    end else if (shr_s > 12'sd255) begin
      val_s = 8'd255;
    end else begin
      val_s = shr_s[7:0];
    end
  end

  assign accept_s    = out_vld_q && out_rdy;
  assign slot_free_s = !out_vld_q || out_rdy;
  assign cnt_inc_s   = win_cnt_q + 10'd1;
  assign last_win_s  = (cnt_inc_s == 10'(WIN_PER_FRAME));
  assign we_s        = w_wr && (state_q == IDLE) && !pix_vld && (w_addr <= 4'd8);

  // Weight file update; only the addressed tap changes.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_d[i] = (we_s && (w_addr == 4'(i))) ? w_data : w_q[i];
    end
  end

  // Window FSM, output slot and frame counter next-state.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    tap_d        = tap_q;
    win_cnt_d    = win_cnt_q;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    last_d       = last_q;
    frame_done_d = accept_s && last_q;
    if (frame_clr) begin
      state_d      = IDLE;
      acc_d        = 12'sd0;
      tap_d        = 4'd0;
      win_cnt_d    = 10'd0;
      out_vld_d    = 1'b0;
      last_d       = 1'b0;
      frame_done_d = 1'b0;
    end else begin
      if (accept_s) begin
        out_vld_d = 1'b0;
        last_d    = 1'b0;
      end else begin
        out_vld_d = out_vld_q;
      end
      case (state_q)
        IDLE: begin
          if (pix_vld) begin
            acc_d   = pix ? tap_ext_s : 12'sd0;
            tap_d   = 4'd1;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (pix_vld) begin
            acc_d   = pix ? (acc_q + tap_ext_s) : acc_q;
            tap_d   = tap_q + 4'd1;
            state_d = (tap_q == 4'd8) ? FIN : ACC;
          end else begin
            state_d = ACC;
          end
        end
        FIN: begin
          // Load may coincide with acceptance of the previous result.
          if (slot_free_s) begin
            out_data_d = val_s;
            out_vld_d  = 1'b1;
            last_d     = last_win_s;
            tap_d      = 4'd0;
            win_cnt_d  = last_win_s ? 10'd0 : cnt_inc_s;
            state_d    = IDLE;
          end else begin
            state_d = FIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 12'sd0;
      tap_q        <= 4'd0;
      win_cnt_q    <= 10'd0;
      out_vld_q    <= 1'b0;
      out_data_q   <= 8'd0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w_q[i] <= 8'sd0;
      end
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tap_q        <= tap_d;
      win_cnt_q    <= win_cnt_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 9; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign bsy        = (state_q != IDLE);
  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule
